// File: rtl/reset_sequencer.sv
// Central reset controller: synchronizes the board reset, applies a power-on hold,
// then releases NUM_STAGES active-low domains in order; a soft request re-runs the sequence.

module reset_sequencer_stage (
  input  logic clk,
  input  logic asyncrst_n,
  input  logic clr_i,
  input  logic set_i,
  output logic rst_n_o
);
  logic rst_n_q, rst_n_d;

  // Clear wins over set so an abort on a release edge keeps the domain held.
  always_comb begin
    rst_n_d = rst_n_q;
    if (clr_i)      rst_n_d = 1'b0;
    else if (set_i) rst_n_d = 1'b1;
  end

  always_ff @(posedge clk or negedge asyncrst_n) begin
    if (!asyncrst_n) rst_n_q <= 1'b0;
    else             rst_n_q <= rst_n_d;
  end

  assign rst_n_o = rst_n_q;
endmodule

module reset_sequencer #(
  parameter int NUM_STAGES = 3,
  parameter int POR_CYCLES = 1024,
  parameter int STAGE_GAP  = 16,
  parameter int MIN_ASSERT = 8
) (
  input  logic                  clk,
  input  logic                  asyncrst_n,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] rst_n_out,
  output logic                  ready,
  output logic                  busy,
  output logic [1:0]            rst_cause
);
  localparam int MAX_AB = (POR_CYCLES > STAGE_GAP) ? POR_CYCLES : STAGE_GAP;
  localparam int MAXC   = (MAX_AB > MIN_ASSERT) ? MAX_AB : MIN_ASSERT;
  localparam int CW     = $clog2(MAXC + 1);
  localparam int IW     = $clog2(NUM_STAGES + 1);

  localparam logic [CW-1:0] POR_LAST = CW'(POR_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] MIN_LAST = CW'(MIN_ASSERT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_STAGES - 1);

  localparam logic [1:0] CAUSE_POR  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;

  typedef enum logic [1:0] {S_HOLD, S_ASSERT, S_RELEASE, S_RUN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic [1:0]      cause_q, cause_d;
  logic [1:0]      sync_q;
  logic            srst_n;
  logic            raise, abort;
  logic [NUM_STAGES-1:0] stage_set;

  // Release of the board reset reaches the FSM two edges later; assertion is immediate.
  always_ff @(posedge clk or negedge asyncrst_n) begin
    if (!asyncrst_n) sync_q <= 2'b00;
    else             sync_q <= {sync_q[0], 1'b1};
  end
  assign srst_n = sync_q[1];

  always_ff @(posedge clk or negedge asyncrst_n) begin
    if (!asyncrst_n) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      cause_q <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    raise   = 1'b0;
    abort   = 1'b0;
    case (state_q)
      S_HOLD: begin
        if (srst_n) begin
          if (cnt_q == POR_LAST) begin
            raise = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_ASSERT: begin
        if (soft_rst_req) begin
          abort = 1'b1;
          cnt_d = '0;
        end else if (cnt_q == MIN_LAST) begin
          raise = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (soft_rst_req) begin
          abort = 1'b1;
          cnt_d = '0;
        end else if (cnt_q == GAP_LAST) begin
          raise = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (soft_rst_req) begin
          abort = 1'b1;
          cnt_d = '0;
        end
      end
      default: state_d = S_HOLD;
    endcase

    if (abort) begin
      state_d = S_ASSERT;
      idx_d   = '0;
    end else if (raise) begin
      if (idx_q == IDX_LAST) begin
        state_d = S_RUN;
        idx_d   = '0;
      end else begin
        state_d = S_RELEASE;
        idx_d   = idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    ready_d = (state_d == S_RUN);
    busy_d  = ~ready_d;
    cause_d = abort ? CAUSE_SOFT : cause_q;
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    assign stage_set[g] = raise && (idx_q == IW'(g));
    reset_sequencer_stage u_stage (
      .clk        (clk),
      .asyncrst_n (asyncrst_n),
      .clr_i      (abort),
      .set_i      (stage_set[g]),
      .rst_n_o    (rst_n_out[g])
    );
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign rst_cause = cause_q;
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Central reset controller for the card's FPGA fabric.
- Synchronizes the board-level asynchronous reset and applies a power-on hold time.
- Releases NUM_STAGES downstream reset domains in a fixed order with a programmable gap: stage 0 (clocking/housekeeping), then bus interface, then relay/scan datapath.
- Accepts a synchronous soft-reset request that re-runs the assert/release sequence without a board reset.

Parameters:
- NUM_STAGES, 3, number of sequenced active-low reset outputs (>=1).
- POR_CYCLES, 1024, clk cycles stage 0 stays held after the synchronized reset deasserts (>=1).
- STAGE_GAP, 16, clk cycles between release of stage k-1 and stage k (>=1).
- MIN_ASSERT, 8, clk cycles all outputs stay low after an accepted soft reset (>=1).

Ports:
- clk, input, 1, system clock.
- asyncrst_n, input, 1, board reset; asynchronous, active-low.
- soft_rst_req, input, 1, synchronous soft-reset request, sampled on every rising clk edge.
- rst_n_out, output, NUM_STAGES, per-domain active-low resets; bit 0 is released first.
- ready, output, 1, high when every stage is released.
- busy, output, 1, high while any sequence is in progress (HOLD, ASSERT or RELEASE).
- rst_cause, output, 2, last reset cause: 01 = board/POR, 10 = soft.

Behaviour:
- Reset and clock: asyncrst_n is an asynchronous, active-low reset; clk is the clock.
- Input synchronizer: 2-flop synchronizer on asyncrst_n.
  - Assertion is asynchronous.
  - Deassertion is synchronous. The internal sync reset goes high after the 2nd rising edge following the asyncrst_n release.
- While asyncrst_n is low (asynchronously, no clock needed):
  - rst_n_out = all 0, ready = 0, busy = 1, rst_cause = 01.
  - FSM = HOLD, counters = 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Counters are sized to the largest of POR_CYCLES, STAGE_GAP and MIN_ASSERT.
- FSM states: HOLD, ASSERT, RELEASE, RUN.
- HOLD:
  - Count clk cycles after the sync reset goes high.
  - Stage 0 is set high on the POR_CYCLES-th rising edge after the sync reset deasserts, i.e. edge 2+POR_CYCLES counted from the asyncrst_n release. Then go to RELEASE with stage index 1.
  - soft_rst_req is ignored in HOLD.
- RELEASE:
  - Every STAGE_GAP cycles, set the next stage high, measured edge to edge from the previous stage's rise.
  - The edge that raises stage NUM_STAGES-1 also sets ready = 1 and busy = 0, and moves the FSM to RUN.
  - If NUM_STAGES = 1, HOLD/ASSERT go directly to RUN on the edge that raises stage 0.
- RUN:
  - soft_rst_req = 1 sampled on edge E: on edge E all rst_n_out go 0, ready = 0, busy = 1, rst_cause = 10, FSM = ASSERT.
- ASSERT:
  - Outputs stay low for exactly MIN_ASSERT cycles.
  - Stage 0 rises on edge E+MIN_ASSERT, then RELEASE proceeds as above.
  - soft_rst_req high while in ASSERT restarts the MIN_ASSERT count from that edge.
- soft_rst_req during RELEASE: aborts the sequence. All outputs go low on the same edge, the FSM enters ASSERT, and the count starts from that edge.
- Release order is monotonic. rst_n_out[k] is never 1 while rst_n_out[k-1] is 0.
- A request held high continuously keeps restarting ASSERT. Release happens only after the request has been low for MIN_ASSERT cycles.
- asyncrst_n assertion at any time (mid-HOLD, mid-RELEASE, RUN):
  - Immediately forces the reset values.
  - rst_cause becomes 01 and overrides a pending soft cause.
- rst_cause is sticky until the next reset event.

Test Plan:
- POR with defaults: release asyncrst_n just before edge 1 -> rst_n_out[0] rises at edge 1026, [1] at 1042, [2] at 1058. ready 0->1 and busy 1->0 at edge 1058. rst_cause = 01.
- Soft reset in RUN: soft_rst_req 1-cycle pulse sampled at edge E -> rst_n_out = 000 and ready = 0 from edge E. Stages rise at E+8, E+24, E+40. rst_cause = 10.
- Abort during RELEASE: pulse at edge 1050 (stage 0 and stage 1 up) -> all outputs 0 at edge 1050. Stages rise at 1058, 1074, 1090. No intermediate glitch high.
- Request ignored in HOLD / restart in ASSERT:
  - Pulse at edge 500 during POR -> timing identical to the POR scenario.
  - Pulses at E and E+5 -> stage 0 rises at E+13.
- Mid-operation board reset: drop asyncrst_n between edges 1045 and 1046, with no clock edge in between -> all outputs 0 immediately and rst_cause = 01. After release, the full POR timing repeats.
- Parameter corner, NUM_STAGES=1, POR_CYCLES=1, MIN_ASSERT=1 -> rst_n_out[0] and ready rise at edge 3. A soft pulse at E gives low for exactly one cycle, high again at E+1. Assertion checks: ordering monotonic, busy == !ready.
